seg7_bcd_reader: RTL and testbench
==================================

SEG7_BCD_READER -- requirements
Module: seg7_bcd_reader

Interface
REQ-001 The block SHALL have one parameter, STABLE_CYCLES, default 4: the consecutive identical samples needed before a pattern is accepted (legal range 1..255).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port seg_n, input, 7 bits: active-low segment lines; bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g; 0 means lit.
REQ-005 Port bcd, output, 4 bits: decoded digit, bit 3 = MSB.
REQ-006 Port out_valid, output, 1 bit: bcd and err carry a report.
REQ-007 Port out_ready, input, 1 bit: the consumer accepts the report.
REQ-008 Port err, output, 1 bit: the report is an undecodable pattern.

Function
REQ-009 seg_n SHALL be registered into seg_q on every edge; all decoding SHALL use seg_q only.
REQ-010 run_cnt SHALL count the consecutive edges on which seg_q received an unchanged value, saturating at STABLE_CYCLES.
- run_cnt SHALL reload to 1 when the sampled value differs from seg_q.
REQ-011 Lit-segment sets SHALL decode as follows:
- 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg; 4 = bcfg
- 5 = acdfg; 6 = acdefg; 7 = abc; 8 = abcdefg; 9 = abcdfg
- Any other set is invalid, except blank.
REQ-012 Blank (seg_q = 7'h7F) SHALL never be reported; a stable blank SHALL set last_pat to 7'h7F so that a repeated digit is re-reported.
REQ-013 State machine states SHALL be:
- IDLE: waiting for a change.
- SETTLE: counting.
- PRESENT: out_valid = 1.
REQ-014 Transitions SHALL be:
- IDLE->SETTLE when seg_q != last_pat.
- SETTLE->PRESENT at the edge where run_cnt reaches STABLE_CYCLES and the pattern is reportable.
- SETTLE->IDLE if seg_q returns to last_pat.
REQ-015 On entry to PRESENT, bcd, err and last_pat SHALL be loaded from the stable pattern.
REQ-016 Latency: with STABLE_CYCLES = 4 and a constant new pattern first sampled at edge k, out_valid SHALL be high after edge k+3.
REQ-017 While out_valid = 1 and out_ready = 0, bcd and err SHALL hold constant regardless of seg_n activity; run_cnt SHALL keep tracking.
REQ-018 On an edge with out_valid = 1 and out_ready = 1, out_valid SHALL deassert and the state SHALL go to IDLE.
- out_valid SHALL stay low for at least one cycle before the next report.
REQ-019 If, at acceptance, seg_q is already stable for STABLE_CYCLES and differs from last_pat, out_valid SHALL reassert on the edge after the low cycle.
REQ-020 out_ready while out_valid = 0 SHALL be ignored.

Reset
REQ-021 On rst = 1 at an edge, the block SHALL clear its outputs: bcd = 0, err = 0, out_valid = 0.
REQ-022 On rst = 1 at an edge, the block SHALL set its internal state: seg_q = 7'h7F, last_pat = 7'h7F, run_cnt = 0, state = IDLE.
REQ-023 Reset during PRESENT SHALL drop out_valid at that edge with no handshake; rst SHALL take priority over all other events.

Configuration
REQ-024 With SEG7_BCD_ERR_EN defined, a stable invalid pattern SHALL be reported with err = 1 and bcd = 4'hF.
REQ-025 With SEG7_BCD_ERR_EN undefined:
- Invalid patterns SHALL be ignored.
- The state SHALL stay IDLE/SETTLE.
- last_pat SHALL remain unchanged.
- err SHALL be constant 0.
- The err port SHALL still exist.

Verification
REQ-026 Reset, then hold seg_n = 7'b0000001 ("0"), out_ready = 1 -> a single out_valid pulse with bcd = 0 after the fourth sampling edge, then no further pulses.
REQ-027 Toggle seg_n between "1" (7'b1001111) and "7" (7'b0001111) every 2 cycles, then settle on "7" -> no report during toggling; exactly one report, bcd = 7.
REQ-028 Present "3" with out_ready = 0 for 10 cycles while seg_n changes to "8" -> bcd stays 3; on out_ready = 1 it is accepted, then after a one-cycle gap out_valid = 1 with bcd = 8.
REQ-029 Sequence "5", blank, "5", each held 6 cycles -> two reports of bcd = 5; blank is not reported.
REQ-030 Stable 7'b0110110 with SEG7_BCD_ERR_EN defined -> err = 1 and bcd = 4'hF; with it undefined -> no out_valid.
REQ-031 Assert rst mid-PRESENT -> out_valid = 0 and bcd = 0 after that edge; re-presenting the same digit is reported again.

Source files
------------

// File: rtl/seg7_bcd_reader.sv
// Debounces an active-low 7-segment input and reports each newly settled digit over a valid/ready handshake.
// Define SEG7_BCD_ERR_EN to also report undecodable stable patterns (err = 1, bcd = 4'hF).
module seg7_bcd_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK    = 7'h7F;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_seg_q;
  logic [6:0]  r_last_pat;
  logic [7:0]  r_run_cnt;
  logic [7:0]  w_run_nxt;
  logic [3:0]  r_bcd;
  logic [4:0]  w_dec;
  logic        w_stable;
  logic        w_blank;
  logic        w_new;
  logic        w_reportable;
  logic        w_load;
  logic        w_blank_clr;

  // {is_digit, digit} for a registered active-low pattern
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      default:    return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    if (seg_n != r_seg_q)
      w_run_nxt = 8'd1;
    else if (r_run_cnt >= STABLE_W)
      w_run_nxt = STABLE_W;
    else
      w_run_nxt = r_run_cnt + 8'd1;
  end

  // Stability is judged on the edge where the count reaches its limit
  assign w_stable = (seg_n == r_seg_q) && (w_run_nxt == STABLE_W);
  assign w_blank  = (r_seg_q == BLANK);
  assign w_new    = (r_seg_q != r_last_pat);
  assign w_dec    = decode(r_seg_q);

`ifdef SEG7_BCD_ERR_EN
  assign w_reportable = w_new && !w_blank;
`else
  assign w_reportable = w_new && !w_blank && w_dec[4];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q   <= BLANK;
      r_run_cnt <= 8'd0;
      r_state   <= IDLE;
    end else begin
      r_seg_q   <= seg_n;
      r_run_cnt <= w_run_nxt;
      r_state   <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_stable && w_reportable)
          w_state_nxt = PRESENT;
        else if (w_new && !(w_stable && w_blank))
          w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!w_new)
          w_state_nxt = IDLE;
        else if (w_stable && w_reportable)
          w_state_nxt = PRESENT;
        else if (w_stable && w_blank)
          w_state_nxt = IDLE;
      end
      PRESENT: begin
        if (out_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Report data is captured only on entry to PRESENT, so it holds while the consumer stalls
  always_comb begin
    out_valid   = (r_state == PRESENT);
    w_load      = (r_state != PRESENT) && w_stable && w_reportable;
    w_blank_clr = (r_state != PRESENT) && w_stable && w_blank && w_new;
  end

`ifdef SEG7_BCD_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd      <= 4'd0;
      r_err      <= 1'b0;
      r_last_pat <= BLANK;
    end else if (w_load) begin
      r_bcd      <= w_dec[4] ? w_dec[3:0] : 4'hF;
      r_err      <= !w_dec[4];
      r_last_pat <= r_seg_q;
    end else if (w_blank_clr) begin
      r_last_pat <= BLANK;
    end
  end

  assign err = r_err;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd      <= 4'd0;
      r_last_pat <= BLANK;
    end else if (w_load) begin
      r_bcd      <= w_dec[3:0];
      r_last_pat <= r_seg_q;
    end else if (w_blank_clr) begin
      r_last_pat <= BLANK;
    end
  end

  assign err = 1'b0;
`endif

  assign bcd = r_bcd;

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// Bench for seg7_bcd_reader: per-cycle comparison against a behavioural model plus targeted sequences.
module tb_seg7_bcd_reader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_n = 7'h7F;
  logic [3:0] bcd;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;

  seg7_bcd_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .bcd(bcd),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Active-low patterns for digits 0..9 (lit segments abcdefg inverted)
  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic [6:0] m_q = 7'h7F, m_last = 7'h7F;
  int         m_run = 0;
  logic       m_valid = 1'b0, m_err = 1'b0;
  logic [3:0] m_bcd = 4'd0;

  int         pulses = 0;
  logic [3:0] p_bcd = 4'd0;
  logic       p_err = 1'b0;
  logic       prev_v = 1'b0;

  function automatic int digit_of(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (pat[i] == s) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [6:0] s, input logic r, input logic rd);
    int d;
    if (r) begin
      m_q = 7'h7F; m_last = 7'h7F; m_run = 0;
      m_valid = 1'b0; m_bcd = 4'd0; m_err = 1'b0;
      return;
    end
    m_run = (s == m_q) ? ((m_run >= S) ? S : m_run + 1) : 1;
    m_q = s;
    if (m_valid) begin
      if (rd) m_valid = 1'b0;
    end else if (m_run == S && m_q != m_last) begin
      d = digit_of(m_q);
      if (m_q == 7'h7F) begin
        m_last = 7'h7F;
      end else if (d >= 0) begin
        m_valid = 1'b1; m_bcd = 4'(d); m_err = 1'b0; m_last = m_q;
      end else begin
`ifdef SEG7_BCD_ERR_EN
        m_valid = 1'b1; m_bcd = 4'hF; m_err = 1'b1; m_last = m_q;
`endif
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [6:0] s, input logic rd, input logic r);
    seg_n = s; out_ready = rd; rst = r;
    @(posedge clk);
    model_edge(s, r, rd);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("err", 32'(err), 32'(m_err));
    if (out_valid && !prev_v) begin
      pulses++; p_bcd = bcd; p_err = err;
    end
    prev_v = out_valid;
  endtask

  task automatic do_reset();
    cyc(7'h7F, 1'b0, 1'b1);
    cyc(7'h7F, 1'b0, 1'b1);
    pulses = 0;
  endtask

  typedef struct {
    logic [6:0] seg;
    int         npulse;
    logic [3:0] bcd;
    logic       err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{pat[i], 1, 4'(i), 1'b0};
    tbl[10] = '{7'h7F, 0, 4'd0, 1'b0};
`ifdef SEG7_BCD_ERR_EN
    tbl[11] = '{7'b0110110, 1, 4'hF, 1'b1};
    tbl[12] = '{7'b1111110, 1, 4'hF, 1'b1};
`else
    tbl[11] = '{7'b0110110, 0, 4'd0, 1'b0};
    tbl[12] = '{7'b1111110, 0, 4'd0, 1'b0};
`endif

    // Reset values
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Latency and single pulse for a held "0"
    for (int i = 1; i <= 4; i++) begin
      cyc(pat[0], 1'b1, 1'b0);
      chk($sformatf("lat_valid_e%0d", i), 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("lat_bcd", 32'(bcd), 32'd0);
    for (int i = 0; i < 10; i++) cyc(pat[0], 1'b1, 1'b0);
    chk("single_pulse", 32'(pulses), 32'd1);

    // Table of held patterns
    for (int t = 0; t < 13; t++) begin
      do_reset();
      for (int i = 0; i < 7; i++) cyc(tbl[t].seg, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_pulses", t), 32'(pulses), 32'(tbl[t].npulse));
      if (tbl[t].npulse > 0) begin
        chk($sformatf("tbl%0d_bcd", t), 32'(p_bcd), 32'(tbl[t].bcd));
        chk($sformatf("tbl%0d_err", t), 32'(p_err), 32'(tbl[t].err));
      end
    end

    // Toggle "1"/"7" every 2 cycles, then settle on "7"
    do_reset();
    for (int i = 0; i < 12; i++) cyc(((i / 2) % 2 == 0) ? pat[1] : pat[7], 1'b1, 1'b0);
    chk("toggle_no_report", 32'(pulses), 32'd0);
    for (int i = 0; i < 8; i++) cyc(pat[7], 1'b1, 1'b0);
    chk("toggle_one_report", 32'(pulses), 32'd1);
    chk("toggle_bcd", 32'(p_bcd), 32'd7);

    // Stalled "3" while input moves to "8"
    do_reset();
    for (int i = 0; i < 4; i++) cyc(pat[3], 1'b0, 1'b0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) cyc(pat[8], 1'b0, 1'b0);
    chk("stall_hold_bcd", 32'(bcd), 32'd3);
    chk("stall_hold_valid", 32'(out_valid), 32'd1);
    cyc(pat[8], 1'b1, 1'b0);
    chk("stall_accept_gap", 32'(out_valid), 32'd0);
    cyc(pat[8], 1'b0, 1'b0);
    chk("stall_next_valid", 32'(out_valid), 32'd1);
    chk("stall_next_bcd", 32'(bcd), 32'd8);
    cyc(pat[8], 1'b1, 1'b0);

    // "5", blank, "5"
    do_reset();
    for (int i = 0; i < 6; i++) cyc(pat[5], 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(pat[5], 1'b1, 1'b0);
    chk("blank_two_reports", 32'(pulses), 32'd2);
    chk("blank_bcd", 32'(p_bcd), 32'd5);

    // Reset while presenting, then re-present the same digit
    do_reset();
    for (int i = 0; i < 5; i++) cyc(pat[4], 1'b0, 1'b0);
    chk("midrst_pre_valid", 32'(out_valid), 32'd1);
    cyc(pat[4], 1'b0, 1'b1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) cyc(pat[4], 1'b1, 1'b0);
    chk("midrst_rereport", 32'(pulses), 32'd1);
    chk("midrst_rebcd", 32'(p_bcd), 32'd4);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int         sel;
      int         hold;
      logic [6:0] s;
      sel = $urandom_range(0, 15);
      if (sel < 10)       s = pat[sel];
      else if (sel < 12)  s = 7'h7F;
      else if (sel == 12) s = 7'($urandom);
      else                s = m_q;
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++)
        cyc(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
